// File: rtl/cc_pkg.sv
// Shared condition-code types and helpers for the SLC-3 CC/BEN unit.
package cc_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_RESET = 3'b010;

  // Zero wins over sign so that an all-zero bus always yields Z.
  function automatic cc_t cc_decode(input logic is_zero, input logic sign);
    cc_t cc;
    cc = '0;
    if (is_zero) begin
      cc.z = 1'b1;
    end else if (sign) begin
      cc.n = 1'b1;
    end else begin
      cc.p = 1'b1;
    end
    return cc;
  endfunction

  function automatic logic ben_eval(input cc_t mask, input cc_t cc);
    return |(mask & cc);
  endfunction

endpackage

// File: rtl/cc_lifo.sv
// LIFO of saved condition codes with level tracking and a sticky misuse flag.
module cc_lifo #(
  parameter int unsigned DEPTH  = 4,
  parameter type         elem_t = cc_pkg::cc_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  elem_t                        wdata,
  output elem_t                        rdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic                         err,
  output logic                         push_ok_c,
  output logic                         pop_ok_c
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  elem_t            mem_q [DEPTH];
  elem_t            mem_d [DEPTH];
  logic [LVL_W-1:0] level_q, level_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] rd_idx;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign err   = err_q;

  // Simultaneous push and pop is treated as misuse and neither takes effect.
  always_comb begin
    push_ok_c = push && !pop && !full;
    pop_ok_c  = pop && !push && !empty;
    err_d     = err_q | (push & pop) | (push & !pop & full) | (pop & !push & empty);
    level_d   = level_q;
    mem_d     = mem_q;
    if (push_ok_c) begin
      mem_d[IDX_W'(level_q)] = wdata;
      level_d                = level_q + LVL_W'(1);
    end else if (pop_ok_c) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_comb begin
    rd_idx = '0;
    if (!empty) begin
      rd_idx = IDX_W'(level_q - LVL_W'(1));
    end
  end

  assign rdata = mem_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Storage needs no reset: entries above the level are don't-care.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cc_ben_unit.sv
// Condition-code register, BEN register and saved-CC LIFO for the SLC-3 datapath.
// Optional feature: define CC_BYPASS_EN to let BEN see the CC being written in the same cycle.
module cc_ben_unit
  import cc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [DATA_W-1:0]           Din,
  input  logic                        LD_CC,
  input  logic                        LD_BEN,
  input  logic [2:0]                  Cond_nzp,
  input  logic                        CC_Push,
  input  logic                        CC_Pop,
  output logic                        BEN_out,
  output logic [2:0]                  CC_out,
  output logic [$clog2(DEPTH+1)-1:0]  Stack_level,
  output logic                        Stack_full,
  output logic                        Stack_empty,
  output logic                        Stack_err
);

  cc_t  cc_q, cc_d;
  cc_t  dec_cc_c, cc_src_c, pop_cc_c;
  logic ben_q, ben_d;
  logic push_ok_c, pop_ok_c;

  cc_lifo #(
    .DEPTH  (DEPTH),
    .elem_t (cc_t)
  ) u_lifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (CC_Push),
    .pop       (CC_Pop),
    .wdata     (cc_q),
    .rdata     (pop_cc_c),
    .level     (Stack_level),
    .full      (Stack_full),
    .empty     (Stack_empty),
    .err       (Stack_err),
    .push_ok_c (push_ok_c),
    .pop_ok_c  (pop_ok_c)
  );

  assign dec_cc_c = cc_decode(Din == '0, Din[DATA_W-1]);

  // A legal pop outranks LD_CC; a rejected pop lets LD_CC through.
  always_comb begin
    cc_d = cc_q;
    if (pop_ok_c) begin
      cc_d = pop_cc_c;
    end else if (LD_CC) begin
      cc_d = dec_cc_c;
    end
  end

  always_comb begin
`ifdef CC_BYPASS_EN
    cc_src_c = (LD_CC || pop_ok_c) ? cc_d : cc_q;
`else
    cc_src_c = cc_q;
`endif
    ben_d = ben_q;
    if (LD_BEN) begin
      ben_d = ben_eval(cc_t'(Cond_nzp), cc_src_c);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cc_q  <= CC_RESET;
      ben_q <= 1'b0;
    end else begin
      cc_q  <= cc_d;
      ben_q <= ben_d;
    end
  end

  assign CC_out  = cc_q;
  assign BEN_out = ben_q;

endmodule

// File: tb/tb_cc_ben_unit.sv
// Self-checking bench for cc_ben_unit: directed cases plus randomized traffic against a queue model.
module tb_cc_ben_unit;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
`ifdef CC_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [DATA_W-1:0] Din;
  logic              LD_CC, LD_BEN, CC_Push, CC_Pop;
  logic [2:0]        Cond_nzp;
  logic              BEN_out;
  logic [2:0]        CC_out;
  logic [LVL_W-1:0]  Stack_level;
  logic              Stack_full, Stack_empty, Stack_err;

  cc_ben_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Din         (Din),
    .LD_CC       (LD_CC),
    .LD_BEN      (LD_BEN),
    .Cond_nzp    (Cond_nzp),
    .CC_Push     (CC_Push),
    .CC_Pop      (CC_Pop),
    .BEN_out     (BEN_out),
    .CC_out      (CC_out),
    .Stack_level (Stack_level),
    .Stack_full  (Stack_full),
    .Stack_empty (Stack_empty),
    .Stack_err   (Stack_err)
  );

  always #5 Clk = ~Clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state
  logic [2:0] m_cc;
  logic       m_ben;
  logic       m_err;
  logic [2:0] m_stk[$];

  function automatic logic [2:0] model_decode(input logic [DATA_W-1:0] d);
    if (d == 0)            return 3'b010;
    else if ($signed(d) < 0) return 3'b100;
    else                   return 3'b001;
  endfunction

  task automatic model_reset();
    m_cc  = 3'b010;
    m_ben = 1'b0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [2:0] nxt;
    logic [2:0] src;
    logic       popped;
    logic [2:0] pval;
    popped = 1'b0;
    pval   = 3'b000;
    if (CC_Push && CC_Pop) begin
      m_err = 1'b1;
    end else if (CC_Push) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else m_stk.push_back(m_cc);
    end else if (CC_Pop) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else begin
        pval   = m_stk.pop_back();
        popped = 1'b1;
      end
    end
    if (popped)     nxt = pval;
    else if (LD_CC) nxt = model_decode(Din);
    else            nxt = m_cc;
    src = (BYPASS && (LD_CC || popped)) ? nxt : m_cc;
    if (LD_BEN) m_ben = |(Cond_nzp & src);
    m_cc = nxt;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    cmp("cc",    32'(CC_out),      32'(m_cc));
    cmp("ben",   32'(BEN_out),     32'(m_ben));
    cmp("level", 32'(Stack_level), 32'(m_stk.size()));
    cmp("full",  32'(Stack_full),  32'(m_stk.size() == DEPTH));
    cmp("empty", 32'(Stack_empty), 32'(m_stk.size() == 0));
    cmp("err",   32'(Stack_err),   32'(m_err));
  endtask

  task automatic drive(input logic ldcc, input logic ldben, input logic push, input logic pop,
                       input logic [DATA_W-1:0] d, input logic [2:0] nzp);
    LD_CC = ldcc; LD_BEN = ldben; CC_Push = push; CC_Pop = pop; Din = d; Cond_nzp = nzp;
  endtask

  task automatic cyc(input logic ldcc, input logic ldben, input logic push, input logic pop,
                     input logic [DATA_W-1:0] d, input logic [2:0] nzp);
    drive(ldcc, ldben, push, pop, d, nzp);
    model_step();
    @(posedge Clk);
    #1;
    check_model();
  endtask

  // Asserts reset mid-cycle while a push is pending; outputs must clear without an edge.
  task automatic async_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h8000, 3'b111);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    cmp("rst_cc",    32'(CC_out),      32'h2);
    cmp("rst_ben",   32'(BEN_out),     32'h0);
    cmp("rst_level", 32'(Stack_level), 32'h0);
    cmp("rst_err",   32'(Stack_err),   32'h0);
    cmp("rst_empty", 32'(Stack_empty), 32'h1);
    cmp("rst_full",  32'(Stack_full),  32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 3'b000);
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    cmp("init_cc", 32'(CC_out), 32'h2);

    // Decode and BEN
    cyc(1, 0, 0, 0, 16'h8000, 3'b000); cmp("dec_neg",  32'(CC_out), 32'h4);
    cyc(1, 0, 0, 0, 16'h0000, 3'b000); cmp("dec_zero", 32'(CC_out), 32'h2);
    cyc(1, 0, 0, 0, 16'h7FFF, 3'b000); cmp("dec_pos",  32'(CC_out), 32'h1);
    cyc(0, 1, 0, 0, 16'h0000, 3'b001); cmp("ben_p",    32'(BEN_out), 32'h1);
    cyc(0, 1, 0, 0, 16'h0000, 3'b110); cmp("ben_nz",   32'(BEN_out), 32'h0);

    // Push with concurrent LD_CC, then pop back
    cyc(1, 0, 0, 0, 16'h8000, 3'b000);
    cyc(1, 0, 1, 0, 16'h0000, 3'b000);
    cmp("push_cc", 32'(CC_out), 32'h2);
    cmp("push_lvl", 32'(Stack_level), 32'h1);
    cyc(0, 0, 0, 1, 16'h0000, 3'b000);
    cmp("pop_cc", 32'(CC_out), 32'h4);
    cmp("pop_lvl", 32'(Stack_level), 32'h0);
    cmp("pop_empty", 32'(Stack_empty), 32'h1);

    // Overflow
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 16'h0000, 3'b000);
    cmp("ovf_full", 32'(Stack_full), 32'h1);
    cmp("ovf_lvl",  32'(Stack_level), 32'h4);
    cmp("ovf_err",  32'(Stack_err), 32'h1);

    // Underflow
    async_reset();
    cyc(0, 0, 0, 1, 16'h0000, 3'b000);
    cmp("unf_cc",  32'(CC_out), 32'h2);
    cmp("unf_err", 32'(Stack_err), 32'h1);

    // Push and pop together, LD_CC still applies
    async_reset();
    cyc(1, 0, 0, 0, 16'h8000, 3'b000);
    cyc(0, 0, 1, 1, 16'h0000, 3'b000);
    cyc(1, 0, 1, 1, 16'h7FFF, 3'b000);
    cmp("pp_lvl", 32'(Stack_level), 32'h0);
    cmp("pp_err", 32'(Stack_err), 32'h1);
    cmp("pp_cc",  32'(CC_out), 32'h1);

    // Merged LD_CC + LD_BEN
    async_reset();
    cyc(1, 0, 0, 0, 16'h7FFF, 3'b000);
    cyc(1, 1, 0, 0, 16'hFFFF, 3'b100);
    cmp("byp_ben", 32'(BEN_out), BYPASS ? 32'h1 : 32'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [DATA_W-1:0] d;
      case ($urandom_range(4))
        0: d = '0;
        1: d = 16'h8000;
        2: d = 16'h7FFF;
        3: d = 16'hFFFF;
        default: d = DATA_W'($urandom);
      endcase
      if (k % 400 == 399) async_reset();
      cyc(($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
          ($urandom % 4) == 0, d, 3'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
